dmem_port_arbiter: RTL and testbench

Shares the single-port, byte-wide data memory of the 16-bit pipelined RISC core between two requesters: the CPU MEM stage and a DMA/loader port. Each 16-bit word access runs as two little-endian byte cycles (low byte at A, high byte at A+1). The CPU has priority, and a starvation guard guarantees the DMA port forward progress. The block stalls the pipeline while a CPU access is outstanding.

---
 rtl/dmem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
`timescale 1ns/1ps
// dmem_port_arbiter
//
// Two requesters share the single-port, byte-wide data memory: the CPU MEM
// stage and a DMA/loader port. Every 16-bit access is split into two byte
// cycles, little-endian: the low byte goes to address A and the high byte to
// A+1, and A+1 wraps inside the memory. The CPU wins arbitration. A wait
// counter makes sure the DMA port is still served when the CPU keeps
// requesting.
//
// Ports:
//   clk, reset_n                 clock; synchronous active-low reset
//   cpu_req/we/addr/wdata        CPU request side, held until cpu_ack
//   cpu_ack, cpu_rdata           one-cycle completion pulse, read data (held)
//   cpu_stall                    cpu_req & ~cpu_ack, pipeline stall
//   dma_req/we/addr/wdata        DMA request side
//   dma_ack, dma_rdata           DMA completion pulse, read data (held)
//   mem_en/we/addr/wdata         byte memory strobe, write enable, address, data
//   mem_rdata                    byte read data, valid the cycle after mem_en
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; arbitrate and latch the winner's request
// LO    | low byte access at A is on the memory bus
// HI    | high byte access at A+1; low read byte is returned this cycle
// ACK   | high read byte is returned; owner's ack is high for one cycle

module dmem_port_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DMA_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_stall,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [15:0]       dma_addr,
    input  logic [15:0]       dma_wdata,
    output logic              dma_ack,
    output logic [15:0]       dma_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int WCW = (DMA_MAX_WAIT < 1) ? 1 : $clog2(DMA_MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(DMA_MAX_WAIT);

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t            state;
    logic [WCW-1:0]    wait_cnt;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [15:0]       lat_wdata;
    logic [7:0]        rd_lo;
    logic [15:0]       cpu_rdata_q;
    logic [15:0]       dma_rdata_q;

    logic              dma_forced;
    logic              cpu_wins;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [15:0]       g_wdata;
    logic              rd_done;

    // Upper address bits fall outside the memory and are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[15:ADDR_W], dma_addr[15:ADDR_W]};

    assign dma_forced = dma_req && (wait_cnt == WAIT_MAX);
    assign cpu_wins   = cpu_req && !dma_forced;

    assign g_we    = cpu_wins ? cpu_we               : dma_we;
    assign g_addr  = cpu_wins ? cpu_addr[ADDR_W-1:0] : dma_addr[ADDR_W-1:0];
    assign g_wdata = cpu_wins ? cpu_wdata            : dma_wdata;

    // The high read byte only arrives in ACK, so the read word is assembled
    // straight from the memory bus that cycle. The registered copy holds it
    // afterwards.
    assign rd_done   = (state == ACK) && !lat_we;
    assign cpu_rdata = (rd_done && owner == OWN_CPU) ? {mem_rdata, rd_lo} : cpu_rdata_q;
    assign dma_rdata = (rd_done && owner == OWN_DMA) ? {mem_rdata, rd_lo} : dma_rdata_q;

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            owner       <= OWN_CPU;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rd_lo       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        lat_we    <= g_we;
                        lat_addr  <= g_addr;
                        lat_wdata <= g_wdata;
                        mem_en    <= 1'b1;
                        mem_we    <= g_we;
                        mem_addr  <= g_addr;
                        mem_wdata <= g_wdata[7:0];
                        state     <= LO;
                        if (cpu_wins) begin
                            owner <= OWN_CPU;
                            if (dma_req && (wait_cnt != WAIT_MAX)) begin
                                wait_cnt <= wait_cnt + 1'b1;
                            end
                        end else begin
                            owner    <= OWN_DMA;
                            wait_cnt <= '0;
                        end
                    end
                end
                LO: begin
                    mem_addr  <= lat_addr + 1'b1;
                    mem_wdata <= lat_wdata[15:8];
                    state     <= HI;
                end
                HI: begin
                    if (!lat_we) begin
                        rd_lo <= mem_rdata;
                    end
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    if (owner == OWN_CPU) begin
                        cpu_ack <= 1'b1;
                    end else begin
                        dma_ack <= 1'b1;
                    end
                    state <= ACK;
                end
                ACK: begin
                    if (!lat_we) begin
                        if (owner == OWN_CPU) begin
                            cpu_rdata_q <= {mem_rdata, rd_lo};
                        end else begin
                            dma_rdata_q <= {mem_rdata, rd_lo};
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        bit         port;
        logic [15:0] rdata;
    } ack_t;

    wr_t  wr_q[$];
    ack_t ack_q[$];
    logic [15:0] last_rd [2];
    logic [7:0]  mem [32];

    dmem_port_arbiter #(.ADDR_W(5), .DMA_MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory with synchronous read.
    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input bit port, input bit we, input logic [15:0] addr,
                                     input logic [15:0] wdata, input logic [15:0] exp_rd);
        wr_t  w;
        ack_t a;
        logic [4:0] a0;
        a0 = addr[4:0];
        if (we) begin
            w.addr = a0;          w.data = wdata[7:0];  wr_q.push_back(w);
            w.addr = a0 + 5'd1;   w.data = wdata[15:8]; wr_q.push_back(w);
        end else begin
            last_rd[port] = exp_rd;
        end
        a.port  = port;
        a.rdata = last_rd[port];
        ack_q.push_back(a);
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL mem_write_unexpected: got %0h@%0d expected none", mem_wdata, mem_addr);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("mem_write_addr", 32'(mem_addr), 32'(w.addr));
                check("mem_write_data", 32'(mem_wdata), 32'(w.data));
            end
        end
        if (mem_en === 1'b0) check("idle_bus_zero", {mem_we, mem_wdata}, 0);
        if (cpu_ack === 1'b1 || dma_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ack_unexpected: got cpu_ack=%0b dma_ack=%0b expected none", cpu_ack, dma_ack);
            end else begin
                ack_t e;
                e = ack_q.pop_front();
                check("ack_both", {31'd0, cpu_ack & dma_ack}, 0);
                check("ack_port", {31'd0, dma_ack}, {31'd0, e.port});
                check("ack_rdata", e.port ? 32'(dma_rdata) : 32'(cpu_rdata), 32'(e.rdata));
            end
        end
    end

    task automatic wait_ack(input bit port, output int lat, output int stall_n);
        lat = 0;
        stall_n = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if ((port ? dma_ack : cpu_ack) === 1'b1) begin
                lat = i;
                break;
            end
            if (cpu_stall === 1'b1) stall_n++;
        end
    endtask

    task automatic txn(input bit port, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rd, input string tag);
        int lat, stl, stl0;
        @(negedge clk);
        push_exp(port, we, addr, wdata, exp_rd);
        if (!port) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end
        #1;
        stl0 = (cpu_stall === 1'b1) ? 1 : 0;
        wait_ack(port, lat, stl);
        check({tag, "_latency"}, lat, 3);
        if (!port) begin
            check({tag, "_stall_cycles"}, stl0 + stl, 3);
            check({tag, "_stall_on_ack"}, {31'd0, cpu_stall}, 0);
            cpu_req = 1'b0;
        end else begin
            dma_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat, stl, acks, since;
        for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;

        // Reset with both requests pending.
        reset_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd2;  cpu_wdata = 16'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'd10; dma_wdata = 16'h0;
        push_exp(1'b0, 1'b0, 16'd2, 16'h0, 16'hA3A2);
        push_exp(1'b1, 1'b0, 16'd10, 16'h0, 16'hABAA);
        repeat (2) begin
            @(negedge clk);
            check("reset_ctrl", {15'd0, cpu_ack, dma_ack, mem_en, mem_we, mem_addr, mem_wdata}, 0);
            check("reset_rdata", {cpu_rdata, dma_rdata}, 0);
        end
        reset_n = 1'b1;
        wait_ack(1'b0, lat, stl);
        check("release_cpu_latency", lat, 3);
        cpu_req = 1'b0;
        wait_ack(1'b1, lat, stl);
        check("release_dma_latency", lat, 4);
        dma_req = 1'b0;

        txn(1'b0, 1'b1, 16'd4,     16'hBEEF, 16'h0,    "cpu_wr_beef");
        txn(1'b0, 1'b0, 16'd4,     16'h0,    16'hBEEF, "cpu_rd_beef");
        txn(1'b1, 1'b1, 16'd31,    16'h1234, 16'h0,    "dma_wr_wrap");
        txn(1'b1, 1'b0, 16'd31,    16'h0,    16'h1234, "dma_rd_wrap");
        txn(1'b0, 1'b1, 16'h0024,  16'hA55A, 16'h0,    "cpu_wr_mask");
        txn(1'b0, 1'b0, 16'd4,     16'h0,    16'hA55A, "cpu_rd_mask");
        txn(1'b1, 1'b0, 16'h0FE4,  16'h0,    16'hA55A, "dma_rd_mask");

        // Contention: both held high, expect C,C,C,C,D twice.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'd31;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) push_exp(1'b0, 1'b0, 16'd0, 16'h0, 16'hA112);
            push_exp(1'b1, 1'b0, 16'd31, 16'h0, 16'h1234);
        end
        acks = 0;
        since = 0;
        for (int i = 0; i < 200 && acks < 10; i++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                since++;
                acks++;
                check("wait_cnt_cpu_grant", 32'(dut.wait_cnt), since);
            end else if (dma_ack === 1'b1) begin
                since = 0;
                acks++;
                check("wait_cnt_after_dma", 32'(dut.wait_cnt), 0);
            end
        end
        check("contention_acks", acks, 10);
        cpu_req = 1'b0;
        dma_req = 1'b0;

        // Reset during HI of a CPU read.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd4;
        @(negedge clk);
        @(negedge clk);
        check("midop_in_hi", 32'(dut.state), 2);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check("midop_no_ack", {31'd0, cpu_ack}, 0);
        check("midop_state_idle", 32'(dut.state), 0);
        check("midop_rdata_cleared", {cpu_rdata, dma_rdata}, 0);
        reset_n = 1'b1;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        txn(1'b0, 1'b0, 16'd4, 16'h0,    16'hA55A, "cpu_rd_after_rst");
        txn(1'b1, 1'b1, 16'd6, 16'h0F0F, 16'h0,    "dma_wr_after_rst");

        repeat (3) @(negedge clk);
        check("wr_queue_empty", wr_q.size(), 0);
        check("ack_queue_empty", ack_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
